// File: rtl/s4ga_cfg_stream.sv
// Configuration streamer: buffers a full LUT bitstream written a byte at a time,
// holds the fabric in reset, then replays the segments on si forever.
module s4ga_cfg_stream #(
  parameter int N    = 16,
  parameter int LL   = 8,
  parameter int SI_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_valid,
  input  logic [7:0]      wr_data,
  output logic            wr_ready,
  input  logic            reload,
  output logic [SI_W-1:0] si,
  output logic            core_rst,
  output logic            frame,
  output logic            loaded,
  output logic [1:0]      dbg_state
);

  localparam int TOTAL   = N * LL;
  localparam int BYTES   = TOTAL / 2;
  localparam int RST_CYC = N + 2;
  localparam int WP_W    = $clog2(BYTES);
  localparam int RP_W    = $clog2(TOTAL);
  localparam int HC_W    = $clog2(RST_CYC);

  typedef enum logic [1:0] {
    ST_LOAD     = 2'd0,
    ST_RST_HOLD = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WP_W-1:0]   wptr_q, wptr_d;
  logic [RP_W-1:0]   rptr_q, rptr_d;
  logic [HC_W-1:0]   hcnt_q, hcnt_d;
  logic [SI_W-1:0]   si_q, si_d;
  logic              core_rst_q, core_rst_d;
  logic              frame_q, frame_d;
  logic              mem_we;
  logic [RP_W-1:0]   widx;
  logic [SI_W-1:0]   mem [TOTAL];

  // Handshake: a byte is taken on a posedge where wr_valid && wr_ready;
  // wr_ready is a pure function of state, so it never waits on wr_valid.
  assign wr_ready  = (state_q == ST_LOAD);
  assign loaded    = (state_q == ST_RST_HOLD) || (state_q == ST_RUN);
  assign si        = si_q;
  assign core_rst  = core_rst_q;
  assign frame     = frame_q;
  assign dbg_state = state_q;
  assign widx      = {wptr_q, 1'b0};

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    hcnt_d     = hcnt_q;
    si_d       = '0;
    core_rst_d = 1'b1;
    frame_d    = 1'b0;
    mem_we     = 1'b0;
    if (reload) begin
      state_d = ST_LOAD;
      wptr_d  = '0;
      rptr_d  = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (wr_valid) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + WP_W'(1);
            if (wptr_q == WP_W'(BYTES - 1)) begin
              state_d = ST_RST_HOLD;
              wptr_d  = '0;
              rptr_d  = '0;
              hcnt_d  = '0;
            end
          end
        end
        ST_RST_HOLD, ST_RUN: begin
          // The last hold cycle already launches mem[0] so RUN cycle 0 shows it.
          if (state_q == ST_RUN || hcnt_q == HC_W'(RST_CYC - 1)) begin
            state_d    = ST_RUN;
            hcnt_d     = '0;
            core_rst_d = 1'b0;
            si_d       = mem[rptr_q];
            frame_d    = (rptr_q == RP_W'(TOTAL - 1));
            rptr_d     = (rptr_q == RP_W'(TOTAL - 1)) ? '0 : rptr_q + RP_W'(1);
          end else begin
            hcnt_d = hcnt_q + HC_W'(1);
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      wptr_q     <= '0;
      rptr_q     <= '0;
      hcnt_q     <= '0;
      si_q       <= '0;
      core_rst_q <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      hcnt_q     <= hcnt_d;
      si_q       <= si_d;
      core_rst_q <= core_rst_d;
      frame_q    <= frame_d;
    end
  end

  // Segment memory keeps its contents across reset and reload.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[widx]             <= wr_data[7:4];
      mem[widx + RP_W'(1)]  <= wr_data[3:0];
    end
  end

endmodule

// File: tb/tb_s4ga_cfg_stream.sv
// Directed bench for s4ga_cfg_stream: loads, hold timing, replay stream,
// reload and asynchronous reset behaviour.
module tb_s4ga_cfg_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       reload;
  logic [3:0] si;
  logic       core_rst;
  logic       frame;
  logic       loaded;
  logic [1:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int hold_k;
  int frames;

  s4ga_cfg_stream dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .reload(reload), .si(si), .core_rst(core_rst),
    .frame(frame), .loaded(loaded), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Byte i of a load is i ^ key; high nibble is the earlier segment.
  function automatic logic [3:0] exp_seg(input int t, input logic [7:0] key);
    int   seg;
    logic [7:0] b;
    seg = t % 128;
    b   = 8'(seg / 2) ^ key;
    return (seg % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic load_bytes(input logic [7:0] key, input bit gaps);
    for (int i = 0; i < 64; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i) ^ key;
      tick();
      if (gaps && i != 63) begin
        wr_valid = 1'b0;
        wr_data  = 8'hEE;
        tick();
      end
    end
    wr_valid = 1'b0;
    wr_data  = 8'h00;
  endtask

  task automatic check_hold();
    chk("after_load_ready", {31'd0, wr_ready}, 32'd0);
    chk("after_load_loaded", {31'd0, loaded}, 32'd1);
    hold_k = 0;
    while (core_rst === 1'b1 && hold_k < 100) begin
      hold_k++;
      tick();
    end
    chk("hold_cycles", hold_k, 32'd18);
  endtask

  task automatic run_check(input int ncyc, input logic [7:0] key, output int nfr);
    nfr = 0;
    for (int t = 0; t < ncyc; t++) begin
      chk($sformatf("si_t%0d", t), {28'd0, si}, {28'd0, exp_seg(t, key)});
      chk($sformatf("frame_t%0d", t), {31'd0, frame}, {31'd0, (t % 128) == 127});
      chk($sformatf("core_rst_t%0d", t), {31'd0, core_rst}, 32'd0);
      if (frame === 1'b1) nfr++;
      tick();
    end
  endtask

  task automatic chk_load_state(input string tag);
    chk({tag, "_ready"}, {31'd0, wr_ready}, 32'd1);
    chk({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
    chk({tag, "_si"}, {28'd0, si}, 32'd0);
    chk({tag, "_frame"}, {31'd0, frame}, 32'd0);
    chk({tag, "_loaded"}, {31'd0, loaded}, 32'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_load_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back load, three passes; writes offered during RUN must be ignored.
    load_bytes(8'h00, 1'b0);
    check_hold();
    wr_valid = 1'b1;
    wr_data  = 8'hFF;
    chk("run_ready", {31'd0, wr_ready}, 32'd0);
    run_check(384, 8'h00, frames);
    chk("frames_3_passes", frames, 32'd3);
    wr_valid = 1'b0;
    wr_data  = 8'h00;

    // Reload at RUN cycle 50 (this is cycle 384 % 128 = 0, so run 50 more).
    run_check(50, 8'h00, frames);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    chk_load_state("reload_run");
    load_bytes(8'h5A, 1'b1);
    check_hold();
    run_check(130, 8'h5A, frames);
    chk("frames_after_reload", frames, 32'd1);

    // Reload together with a write at wptr=10: byte dropped, wptr back to 0.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = 8'(i);
      tick();
    end
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    reload   = 1'b1;
    tick();
    reload   = 1'b0;
    wr_valid = 1'b0;
    chk_load_state("reload_write");
    load_bytes(8'h00, 1'b1);
    check_hold();
    run_check(130, 8'h00, frames);

    // Asynchronous reset mid-RUN, between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    chk_load_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_load_state($sformatf("post_rst%0d", i));
    end
    load_bytes(8'hC3, 1'b0);
    check_hold();
    run_check(130, 8'hC3, frames);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/s4ga_cfg_stream.md
S4GA_CFG_STREAM -- requirements
Module: s4ga_cfg_stream

Interface
REQ-001 Parameter N, default 16: number of LUTs in the downstream fabric.
REQ-002 Parameter LL, default 8: SI segments per LUT config.
REQ-003 Parameter SI_W, default 4: segment width; fixed at 4, so 8 / SI_W = 2 segments per byte.
REQ-004 Derived: TOTAL = N*LL segments (128); BYTES = TOTAL/2 (64); RST_CYC = N+2 (18).
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 wr_valid  input  1  config byte offered.
REQ-008 wr_data  input  8  config byte; high nibble is the earlier segment (big-endian).
REQ-009 wr_ready  output  1  byte accepted when wr_valid && wr_ready at posedge.
REQ-010 reload  input  1  single-cycle request to discard the stream and re-enter LOAD.
REQ-011 si  output  SI_W  registered segment stream to the fabric si pins.
REQ-012 core_rst  output  1  registered active-high sync reset to the fabric.
REQ-013 frame  output  1  registered one-cycle pulse coinciding with the last segment of a full N-LUT pass.
REQ-014 loaded  output  1  high while in RST_HOLD or RUN.

Function
REQ-015 Storage: TOTAL x SI_W segment memory, write pointer wptr (0..BYTES-1), read pointer rptr (0..TOTAL-1), hold counter hcnt.
REQ-016 FSM states: LOAD, RST_HOLD, RUN.
REQ-017 LOAD: wr_ready=1, core_rst=1, si=0, frame=0.
REQ-018 In LOAD, each accepted byte stores the high nibble at mem[2*wptr] and the low nibble at mem[2*wptr+1], then increments wptr.
REQ-019 Accepting byte BYTES-1 sends LOAD->RST_HOLD; wr_ready=0 from the next cycle; hcnt=0, rptr=0.
REQ-020 RST_HOLD: core_rst=1 and si=0 for exactly RST_CYC cycles (hcnt 0..RST_CYC-1), then RUN.
REQ-021 RUN: core_rst=0; on RUN cycle t (t=0 is the first), si = mem[t mod TOTAL]; rptr increments each cycle and wraps TOTAL-1 -> 0.
REQ-022 frame=1 exactly on the cycles where si carries mem[TOTAL-1]; otherwise 0.
REQ-023 reload=1 in any state: on the next cycle the block is in LOAD with wptr=0, rptr=0, hcnt=0, core_rst=1, si=0, frame=0.
REQ-024 Memory contents are not cleared by reload.
REQ-025 reload wins over a simultaneous accepted write; that byte is dropped.
REQ-026 wr_valid is ignored outside LOAD; wr_data has no effect when the write is not accepted.
REQ-027 wr_ready depends only on state, never on wr_valid (no combinational path).
REQ-028 Gaps in wr_valid during LOAD stall wptr with no side effects.

Reset
REQ-029 rst_n low asynchronously forces state=LOAD, wptr=rptr=hcnt=0, si=0, core_rst=1, frame=0, loaded=0, wr_ready=1.
REQ-030 Memory is not reset.
REQ-031 Release of rst_n is synchronous to clk; the first write can be accepted on the first posedge after release.
REQ-032 Assertion of rst_n mid-LOAD or mid-RUN discards all progress.

Verification
REQ-033 Write 64 bytes 0x00..0x3F back-to-back -> wr_ready falls after byte 63; core_rst high 18 cycles; then si = 0,0,0,1,0,2,...,3,F; frame pulses with si=F every 128 cycles.
REQ-034 Same load with wr_valid toggling every other cycle -> identical si sequence; wptr advances only on handshakes.
REQ-035 reload asserted at RUN cycle 50 -> next cycle core_rst=1, si=0, wr_ready=1; a new 64-byte load restarts the sequence from mem[0].
REQ-036 reload together with a valid write in LOAD at wptr=10 -> byte not stored; wptr=0 next cycle.
REQ-037 rst_n pulsed low mid-RUN (asynchronously, between edges) -> outputs reach reset values immediately; after release, a full reload is required.
REQ-038 Run 3 full passes -> frame count=3; the si stream is periodic with period 128; core_rst stays 0 throughout.
